// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
//
// Data-memory request/acknowledge bus between the MEM stage and the data
// memory (or its arbiter).
//
// Signals:
//   dmem_req    stage -> mem  request; held high for the whole access
//   dmem_we     stage -> mem  1 = store, 0 = load
//   dmem_addr   stage -> mem  word-aligned byte address
//   dmem_wdata  stage -> mem  store data
//   dmem_rdata  mem -> stage  load data, valid while dmem_ack = 1
//   dmem_ack    mem -> stage  access complete; meaningful only while dmem_req = 1
//
// Modports:
//   master  the pipeline stage issuing accesses
//   slave   the memory answering them
// -----------------------------------------------------------------------------
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of the pipeline. Consumes the EX/MEM register fields, performs the
// data-memory access over the req/ack bus, holds the upstream pipeline while an
// access is in flight, and drives the MEM/WB register fields for write-back.
// Misaligned accesses are dropped (never reach the bus) and accesses that see
// no ack within TIMEOUT cycles are aborted; both leave the pipe as a bubble
// and raise a one-cycle error pulse.
//
// Parameters:
//   TIMEOUT         max ACCESS cycles without ack before abort (2..255)
//
// Ports:
//   clk, rst        clock (rising edge) / asynchronous active-high reset
//   mem_read_mem    load request from EX/MEM
//   mem_write_mem   store request from EX/MEM
//   mem_to_reg_mem  write-back select from EX/MEM
//   reg_write_mem   register-write enable from EX/MEM
//   address_mem     ALU result / memory byte address
//   write_data_mem  store data
//   reg_dst_mem     destination register
//   stall           combinational hold for EX/MEM and earlier stages
//   dmem            data-memory bus (master side)
//   read_data_wb    load result to MEM/WB
//   alu_result_wb   address_mem passthrough to MEM/WB
//   reg_dst_wb      destination register to MEM/WB
//   mem_to_reg_wb   write-back select to MEM/WB
//   reg_write_wb    register-write enable to MEM/WB
//   misalign_err    one-cycle pulse: misaligned access dropped
//   timeout_err     one-cycle pulse: access aborted on timeout
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               mem_read_mem,
  input  logic               mem_write_mem,
  input  logic               mem_to_reg_mem,
  input  logic               reg_write_mem,
  input  logic [31:0]        address_mem,
  input  logic [31:0]        write_data_mem,
  input  logic [4:0]         reg_dst_mem,

  output logic               stall,

  mem_access_stage_if.master dmem,

  output logic [31:0]        read_data_wb,
  output logic [31:0]        alu_result_wb,
  output logic [4:0]         reg_dst_wb,
  output logic               mem_to_reg_wb,
  output logic               reg_write_wb,
  output logic               misalign_err,
  output logic               timeout_err
);

  // Last ACCESS cycle index that may still complete; the counter starts at 0
  // on the first ACCESS cycle, so TIMEOUT ACCESS cycles end at TIMEOUT-1.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // FSM and bus registers
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  // MEM/WB registers
  logic [31:0] rdata_wb_q, rdata_wb_d;
  logic [31:0] alu_wb_q, alu_wb_d;
  logic [4:0]  rd_wb_q, rd_wb_d;
  logic        m2r_wb_q, m2r_wb_d;
  logic        rw_wb_q, rw_wb_d;
  logic        mis_q, mis_d;
  logic        tmo_q, tmo_d;

  // Decode of the instruction currently held in EX/MEM
  logic mem_op;
  logic aligned;
  logic go;
  logic misaligned_op;
  logic dual_req;

  // Access progress
  logic in_access;
  logic tmo_hit;
  logic ack_done;
  logic tmo_done;

  assign mem_op        = mem_read_mem | mem_write_mem;
  assign aligned       = (address_mem[1:0] == 2'b00);
  assign go            = mem_op & aligned;
  assign misaligned_op = mem_op & ~aligned;
  assign dual_req      = mem_read_mem & mem_write_mem;

  assign in_access = (state_q == ACCESS);
  assign tmo_hit   = (cnt_q == TMO_LAST);
  // An ack only counts while a request is outstanding; in IDLE it is ignored.
  assign ack_done  = in_access & dmem.dmem_ack;
  assign tmo_done  = in_access & ~dmem.dmem_ack & tmo_hit;

  // The held instruction may advance in the cycle its access finishes
  // (ack or abort), so the pipe resumes without a dead cycle.
  assign stall = go & ~(in_access & (dmem.dmem_ack | tmo_hit));

  // ---------------------------------------------------------------------------
  // Access FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = ACCESS;
          req_d   = 1'b1;
          // Store wins when read and write are requested together.
          we_d    = mem_write_mem;
          addr_d  = {address_mem[31:2], 2'b00};
          wdata_d = write_data_mem;
          cnt_d   = 8'd0;
        end
      end

      ACCESS: begin
        if (dmem.dmem_ack || tmo_hit) begin
          state_d = IDLE;
          req_d   = 1'b0;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // MEM/WB next state
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_wb_d = rdata_wb_q;
    alu_wb_d   = alu_wb_q;
    rd_wb_d    = rd_wb_q;
    m2r_wb_d   = m2r_wb_q;
    rw_wb_d    = rw_wb_q;

    if (stall) begin
      // Bubble into WB while the access is outstanding; data fields hold.
      rw_wb_d  = 1'b0;
      m2r_wb_d = 1'b0;
    end else begin
      alu_wb_d = address_mem;
      rd_wb_d  = reg_dst_mem;
      m2r_wb_d = mem_to_reg_mem;
      // Aborted, dropped and ambiguous read+write instructions never write
      // the register file.
      rw_wb_d  = reg_write_mem & ~tmo_done & ~misaligned_op & ~dual_req;
    end

    if (ack_done && !we_q) begin
      rdata_wb_d = dmem.dmem_rdata;
    end

    mis_d = misaligned_op;
    tmo_d = tmo_done;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_wb_q <= 32'd0;
      alu_wb_q   <= 32'd0;
      rd_wb_q    <= 5'd0;
      m2r_wb_q   <= 1'b0;
      rw_wb_q    <= 1'b0;
      mis_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_wb_q <= rdata_wb_d;
      alu_wb_q   <= alu_wb_d;
      rd_wb_q    <= rd_wb_d;
      m2r_wb_q   <= m2r_wb_d;
      rw_wb_q    <= rw_wb_d;
      mis_q      <= mis_d;
      tmo_q      <= tmo_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign read_data_wb  = rdata_wb_q;
  assign alu_result_wb = alu_wb_q;
  assign reg_dst_wb    = rd_wb_q;
  assign mem_to_reg_wb = m2r_wb_q;
  assign reg_write_wb  = rw_wb_q;
  assign misalign_err  = mis_q;
  assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Scoreboard bench for mem_access_stage. Each instruction is presented to the
// stage together with the ack latency the memory model should use; the
// expected MEM/WB result is pushed when the instruction is driven and popped
// when the stage lets the instruction go (stall low at the retiring edge).
// A behavioural memory answers dmem_req after a programmable number of cycles.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int TIMEOUT = 16;
  localparam int BOUND   = 300;

  logic        clk = 1'b0;
  logic        rst;

  logic        mem_read_mem;
  logic        mem_write_mem;
  logic        mem_to_reg_mem;
  logic        reg_write_mem;
  logic [31:0] address_mem;
  logic [31:0] write_data_mem;
  logic [4:0]  reg_dst_mem;
  logic        stall;
  logic [31:0] read_data_wb;
  logic [31:0] alu_result_wb;
  logic [4:0]  reg_dst_wb;
  logic        mem_to_reg_wb;
  logic        reg_write_wb;
  logic        misalign_err;
  logic        timeout_err;

  mem_access_stage_if dmem_bus ();

  mem_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read_mem   (mem_read_mem),
    .mem_write_mem  (mem_write_mem),
    .mem_to_reg_mem (mem_to_reg_mem),
    .reg_write_mem  (reg_write_mem),
    .address_mem    (address_mem),
    .write_data_mem (write_data_mem),
    .reg_dst_mem    (reg_dst_mem),
    .stall          (stall),
    .dmem           (dmem_bus),
    .read_data_wb   (read_data_wb),
    .alu_result_wb  (alu_result_wb),
    .reg_dst_wb     (reg_dst_wb),
    .mem_to_reg_wb  (mem_to_reg_wb),
    .reg_write_wb   (reg_write_wb),
    .misalign_err   (misalign_err),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory model: acks on the ack_after-th cycle of dmem_req (0 = never).
  // force_ack drives ack regardless of dmem_req.
  // ---------------------------------------------------------------------------
  int          ack_after = 0;
  logic [31:0] ack_rdata = 32'h0;
  logic        force_ack = 1'b0;

  initial begin
    int k;
    k = 0;
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (dmem_bus.dmem_req === 1'b1) k++;
      else k = 0;
      if (dmem_bus.dmem_req === 1'b1 && ack_after > 0 && k == ack_after) begin
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = ack_rdata;
      end else begin
        dmem_bus.dmem_ack   = force_ack;
        dmem_bus.dmem_rdata = $urandom;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        m2r;
    logic        rw;
    logic        we;
    logic        mis;
    logic        tmo;
    int          stall_cyc;
    int          req_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_rdata = 32'h0;

  task automatic drive_nop();
    mem_read_mem   = 1'b0;
    mem_write_mem  = 1'b0;
    mem_to_reg_mem = 1'b0;
    reg_write_mem  = 1'b0;
    address_mem    = 32'h0;
    write_data_mem = 32'h0;
    reg_dst_mem    = 5'd0;
  endtask

  // Called and returns at posedge+1.
  task automatic issue(input logic mr, input logic mw, input logic m2r, input logic rw,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input int n_ack, input logic [31:0] rdata);
    exp_t e;
    exp_t got;
    logic mem_op, go, done_ok, st, retired;
    int   n_stall, n_req;

    mem_op  = mr | mw;
    go      = mem_op & (addr[1:0] == 2'b00);
    done_ok = go && n_ack >= 1 && n_ack <= TIMEOUT;

    e.alu   = addr;
    e.rd    = rd;
    e.m2r   = m2r;
    e.tmo   = go && !done_ok;
    e.mis   = mem_op && !go;
    e.rw    = rw && !e.tmo && !e.mis && !(mr && mw);
    if (done_ok && !mw) model_rdata = rdata;
    e.rdata = model_rdata;
    e.we    = mw;
    e.addr  = {addr[31:2], 2'b00};
    e.wdata = wdata;
    e.stall_cyc = go ? (done_ok ? n_ack : TIMEOUT) : 0;
    e.req_cyc   = e.stall_cyc;
    sb.push_back(e);

    ack_after      = n_ack;
    ack_rdata      = rdata;
    mem_read_mem   = mr;
    mem_write_mem  = mw;
    mem_to_reg_mem = m2r;
    reg_write_mem  = rw;
    address_mem    = addr;
    write_data_mem = wdata;
    reg_dst_mem    = rd;

    n_stall = 0;
    n_req   = 0;
    retired = 1'b0;
    for (int cyc = 0; cyc < BOUND; cyc++) begin
      @(negedge clk);
      st = stall;
      if (stall === 1'b1) n_stall++;
      if (dmem_bus.dmem_req === 1'b1) begin
        n_req++;
        chk_eq("dmem_we", 32'(dmem_bus.dmem_we), 32'(e.we));
        chk_eq("dmem_addr", dmem_bus.dmem_addr, e.addr);
        chk_eq("dmem_wdata", dmem_bus.dmem_wdata, e.wdata);
      end
      @(posedge clk);
      if (st !== 1'b1) begin
        retired = 1'b1;
        break;
      end
    end
    if (!retired) chk_eq("retire_bound", 32'(retired), 32'd1);
    #1;

    got = sb.pop_front();
    chk_eq("alu_result_wb", alu_result_wb, got.alu);
    chk_eq("reg_dst_wb", 32'(reg_dst_wb), 32'(got.rd));
    chk_eq("mem_to_reg_wb", 32'(mem_to_reg_wb), 32'(got.m2r));
    chk_eq("reg_write_wb", 32'(reg_write_wb), 32'(got.rw));
    chk_eq("read_data_wb", read_data_wb, got.rdata);
    chk_eq("misalign_err", 32'(misalign_err), 32'(got.mis));
    chk_eq("timeout_err", 32'(timeout_err), 32'(got.tmo));
    chk_eq("dmem_req_after", 32'(dmem_bus.dmem_req), 32'd0);
    chk_eq("stall_cycles", 32'(n_stall), 32'(got.stall_cyc));
    chk_eq("req_cycles", 32'(n_req), 32'(got.req_cyc));
  endtask

  task automatic nop();
    issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_req"}, 32'(dmem_bus.dmem_req), 32'd0);
    chk_eq({tag, "_we"}, 32'(dmem_bus.dmem_we), 32'd0);
    chk_eq({tag, "_addr"}, dmem_bus.dmem_addr, 32'd0);
    chk_eq({tag, "_wdata"}, dmem_bus.dmem_wdata, 32'd0);
    chk_eq({tag, "_stall"}, 32'(stall), 32'd0);
    chk_eq({tag, "_rdata_wb"}, read_data_wb, 32'd0);
    chk_eq({tag, "_alu_wb"}, alu_result_wb, 32'd0);
    chk_eq({tag, "_rd_wb"}, 32'(reg_dst_wb), 32'd0);
    chk_eq({tag, "_m2r_wb"}, 32'(mem_to_reg_wb), 32'd0);
    chk_eq({tag, "_rw_wb"}, 32'(reg_write_wb), 32'd0);
    chk_eq({tag, "_mis"}, 32'(misalign_err), 32'd0);
    chk_eq({tag, "_tmo"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    drive_nop();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Non-memory op passes straight through
    issue(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0);
    nop();

    // Load, ack on the 3rd ACCESS cycle
    issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
    nop();

    // Store, ack on the 1st ACCESS cycle; read_data_wb must hold
    issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 5'd0, 1, 32'h1357_9BDF);

    // Misaligned load is dropped
    issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0102, 32'h0, 5'd9, 1, 32'h5555_5555);
    nop();

    // Load never acked: aborts after TIMEOUT cycles
    issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd10, 0, 32'h0);

    // Late ack while no request is outstanding is ignored
    force_ack = 1'b1;
    nop();
    force_ack = 1'b0;
    nop();

    // Back-to-back loads; second acks on the last allowed cycle
    issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 5'd11, 2, 32'h1111_1111);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0404, 32'h0, 5'd12, TIMEOUT, 32'h2222_2222);

    // Read and write together: store wins, no register write
    issue(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'hA5A5_5A5A, 5'd13, 2, 32'h3333_3333);

    // Mixed random traffic
    for (int i = 0; i < 8; i++) begin
      int          op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a  = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      case (op)
        0: issue(1'b0, 1'b0, 1'b0, 1'b1, $urandom, 32'h0, 5'($urandom_range(1, 31)), 0, 32'h0);
        1: issue(1'b1, 1'b0, 1'b1, 1'b1, a, 32'h0, 5'($urandom_range(1, 31)),
                 $urandom_range(1, 5), $urandom);
        default: issue(1'b0, 1'b1, 1'b0, 1'b0, a, $urandom, 5'd0, $urandom_range(1, 5), $urandom);
      endcase
    end

    // Reset asserted on the 2nd ACCESS cycle of a load
    ack_after      = 0;
    mem_read_mem   = 1'b1;
    mem_to_reg_mem = 1'b1;
    reg_write_mem  = 1'b1;
    address_mem    = 32'h0000_0600;
    reg_dst_mem    = 5'd14;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_eq("pre_rst_req", 32'(dmem_bus.dmem_req), 32'd1);
    #1;
    rst = 1'b1;
    drive_nop();
    #1;
    check_all_zero("mid_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_rdata = 32'h0;

    // Fresh load after reset
    issue(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0700, 32'h0, 5'd15, 2, 32'h0BAD_CAFE);
    nop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Performs the data-memory access over a req/ack handshake and stalls the upstream pipeline while an access is outstanding.
- Checks word alignment and bounds each access with a timeout.
- Drives the MEM/WB register fields consumed by write-back.

Parameters:
TIMEOUT, 16, max ACCESS cycles without ack before abort; legal range 2..255; 8-bit internal counter.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
mem_read_mem  in  1  load request from EX/MEM
mem_write_mem  in  1  store request from EX/MEM
mem_to_reg_mem  in  1  write-back select from EX/MEM
reg_write_mem  in  1  register-write enable from EX/MEM
address_mem  in  32  ALU result / memory byte address
write_data_mem  in  32  store data
reg_dst_mem  in  5  destination register
stall  out  1  combinational; upstream holds EX/MEM and earlier stages while high
dmem_req  out  1  memory request; registered
dmem_we  out  1  1=store, 0=load; registered
dmem_addr  out  32  word-aligned address; registered
dmem_wdata  out  32  store data; registered
dmem_rdata  in  32  load data, valid when dmem_ack=1
dmem_ack  in  1  access complete; sampled only while dmem_req=1
read_data_wb  out  32  load result to MEM/WB
alu_result_wb  out  32  address_mem passthrough to MEM/WB
reg_dst_wb  out  5  destination register to MEM/WB
mem_to_reg_wb  out  1  write-back select to MEM/WB
reg_write_wb  out  1  register-write enable to MEM/WB
misalign_err  out  1  one-cycle pulse: misaligned access dropped
timeout_err  out  1  one-cycle pulse: access aborted on timeout

Behaviour:
- Reset: every output 0; state IDLE; timeout counter 0. Reset asserted mid-access drops dmem_req immediately and discards the access; no WB effect.
- Definitions:
  - mem_op = mem_read_mem | mem_write_mem.
  - aligned = (address_mem[1:0] == 0).
  - go = mem_op & aligned.
- Simultaneous read and write requests: store wins; reg_write_wb is forced to 0 for that instruction.
- stall = go & ~(state==ACCESS & (dmem_ack | tmo_hit)), where tmo_hit = (cnt == TIMEOUT-1).
- FSM states: IDLE, ACCESS.
  - IDLE & go: next state ACCESS. Latch dmem_addr = {address_mem[31:2], 2'b00}, dmem_wdata = write_data_mem, dmem_we = mem_write_mem. Set dmem_req = 1, cnt = 0.
  - IDLE & ~go: stay in IDLE.
  - ACCESS & dmem_ack: return to IDLE with dmem_req = 0. If load, read_data_wb = dmem_rdata.
  - ACCESS & ~dmem_ack & tmo_hit: return to IDLE with dmem_req = 0. Pulse timeout_err for one cycle.
  - ACCESS otherwise: cnt increments. dmem_addr, dmem_we, dmem_wdata and dmem_req are held stable.
- MEM/WB update on every rising edge:
  - If stall=1: load a bubble (reg_write_wb = 0, mem_to_reg_wb = 0); other fields hold.
  - Else (no stall): alu_result_wb = address_mem, reg_dst_wb = reg_dst_mem, mem_to_reg_wb = mem_to_reg_mem, reg_write_wb = reg_write_mem.
  - Force reg_write_wb = 0 when any of these hold:
    - the access timed out this cycle;
    - mem_op is set and the address is misaligned;
    - read and write were requested together.
  - read_data_wb changes only on load completion; otherwise it holds.
- Misaligned mem_op:
  - No dmem_req is issued and stall stays 0.
  - misalign_err is set at the next edge for one cycle.
  - The instruction leaves as a bubble.
- Latency:
  - Non-memory op: 1 cycle, no stall.
  - Memory op: 1 IDLE cycle plus N ACCESS cycles, where N is the cycle on which ack arrives (1..TIMEOUT).
  - stall is high for N cycles total.
  - reg_write_wb is high for exactly one cycle per completed instruction.
- dmem_ack seen while dmem_req=0 is ignored.
- Back-to-back memory ops: the next op is presented the cycle after completion; IDLE re-detects it. There is always at least one dmem_req=0 cycle between accesses.

Test Plan:
- Non-mem op: reg_write_mem=1, address_mem=0x0000_1234, reg_dst_mem=5 -> next edge alu_result_wb=0x1234, reg_dst_wb=5, reg_write_wb=1; stall and dmem_req never high.
- Load at addr 0x100, ack on 3rd ACCESS cycle with rdata=0xDEADBEEF -> stall high 3 cycles, dmem_req high 3 cycles, dmem_we=0; read_data_wb=0xDEADBEEF, mem_to_reg_wb=1, reg_write_wb=1 for one cycle.
- Store at addr 0x204, wdata 0xCAFEF00D, ack on 1st ACCESS cycle -> dmem_we=1, dmem_addr=0x204, dmem_wdata=0xCAFEF00D; stall high 1 cycle; read_data_wb unchanged.
- Misaligned load at 0x102 -> no dmem_req, stall=0, misalign_err pulse of 1 cycle, reg_write_wb=0.
- Load with ack never asserted, TIMEOUT=16 -> dmem_req high 16 cycles, then timeout_err 1-cycle pulse, stall drops, reg_write_wb stays 0; a late ack is ignored.
- rst pulsed on the 2nd ACCESS cycle -> dmem_req=0 and all outputs 0 immediately; after release, a fresh load completes normally.
